// File: rtl/parity_pkg.sv
// Shared types for the parity frame controller: FSM encoding, tracker encoding, result record.
// Pure declarations, no logic.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef struct packed {
    logic par;
    logic err;
  } result_t;

endpackage

// File: rtl/parity_tracker.sv
// Serial parity accumulator: one bit folded in per enabled cycle, clear wins over enable.
// Result visible the cycle after the bit is presented; never stalls.
module parity_tracker
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic par
);

  logic par_q;
  logic par_d;

  always_comb begin
    par_d = par_q;
    if (clr) begin
      par_d = EVEN;
    end else if (en) begin
      par_d = par_q ^ bit_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= EVEN;
    end else begin
      par_q <= par_d;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/parity_frame_ctrl.sv
// Shifts one accepted word LSB-first through a parity tracker and reports parity/mismatch; DATA_W+2 cycles per frame.
// Input is taken only in IDLE; the result is held until out_ready, and flush aborts any frame in flight.
module parity_frame_ctrl
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_par,
  output logic              out_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int                BC_W     = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  state_e             state_q,     state_d;
  logic [DATA_W-1:0]  sreg_q,      sreg_d;
  logic [BC_W-1:0]    bit_cnt_q,   bit_cnt_d;
  logic               exp_par_q,   exp_par_d;
  result_t            res_q,       res_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   err_cnt_q,   err_cnt_d;

  logic trk_clr;
  logic trk_en;
  logic trk_par;
  logic fin_par;

  parity_tracker u_tracker (
    .clk    (clk),
    .rst    (rst),
    .clr    (trk_clr),
    .en     (trk_en),
    .bit_in (sreg_q[0]),
    .par    (trk_par)
  );

  // The last bit lands in the tracker on the same edge the result is captured,
  // so the final parity is formed from the tracker output plus the bit in flight.
  assign fin_par = (trk_par ^ sreg_q[0]) ^ ODD_PARITY;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    bit_cnt_d   = bit_cnt_q;
    exp_par_d   = exp_par_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    trk_clr     = 1'b0;
    trk_en      = 1'b0;

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      trk_clr     = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sreg_d    = in_data;
            exp_par_d = in_par;
            bit_cnt_d = '0;
            trk_clr   = 1'b1;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          trk_en    = 1'b1;
          sreg_d    = sreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            res_d.par   = fin_par;
            res_d.err   = fin_par ^ exp_par_q;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            if (res_q.err && (err_cnt_q != CNT_MAX)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      exp_par_q   <= 1'b0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      bit_cnt_q   <= bit_cnt_d;
      exp_par_q   <= exp_par_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_par   = res_q.par;
  assign out_err   = res_q.err;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Scoreboard bench: an even-parity 8-bit-counter instance and an odd-parity 2-bit-counter instance
// driven in lockstep from the same stimulus.
module tb_parity_frame_ctrl;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_par;
  logic [DW-1:0] in_data;
  logic          out_ready;

  logic       a_in_ready, a_out_valid, a_out_par, a_out_err, a_busy;
  logic [7:0] a_err_cnt;
  logic       b_in_ready, b_out_valid, b_out_par, b_out_err, b_busy;
  logic [1:0] b_err_cnt;

  typedef struct packed {
    logic par;
    logic err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cnt_a   = 0;
  int   cnt_b   = 0;

  always #5 clk = ~clk;

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(1'b0), .CNT_W(8)) dut_even (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_par(a_out_par), .out_err(a_out_err),
    .busy(a_busy), .err_cnt(a_err_cnt)
  );

  parity_frame_ctrl #(.DATA_W(DW), .ODD_PARITY(1'b1), .CNT_W(2)) dut_odd (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data), .in_par(in_par),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_par(b_out_par), .out_err(b_out_err),
    .busy(b_busy), .err_cnt(b_err_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Result monitor: pops the scoreboard on every result handshake.
  always @(negedge clk) begin
    if (!rst && !flush && out_ready && a_out_valid) begin
      check_eq("a_q_nonempty", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        ea = q_a.pop_front();
        check_eq("a_out_par", a_out_par, ea.par);
        check_eq("a_out_err", a_out_err, ea.err);
        if (ea.err && cnt_a < 255) cnt_a++;
      end
    end
    if (!rst && !flush && out_ready && b_out_valid) begin
      check_eq("b_q_nonempty", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        eb = q_b.pop_front();
        check_eq("b_out_par", b_out_par, eb.par);
        check_eq("b_out_err", b_out_err, eb.err);
        if (eb.err && cnt_b < 3) cnt_b++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic p);
    exp_t e;
    int   guard = 0;
    while (!a_in_ready && guard < 40) begin
      tick();
      guard++;
    end
    check_eq("send_in_ready", a_in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    e.par = ^d;
    e.err = e.par ^ p;
    q_a.push_back(e);
    e.par = ~(^d);
    e.err = e.par ^ p;
    q_b.push_back(e);
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    in_par   = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_out_valid && lat < 40);
    check_eq("a_out_vld_timeout", a_out_valid, 1'b1);
    check_eq("b_out_vld", b_out_valid, 1'b1);
    tick();
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int sat_exp[4] = '{1, 2, 3, 3};
    logic seen_vld;
    logic [DW-1:0] rd;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_par = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    check_eq("rst_in_ready", a_in_ready, 1'b1);
    check_eq("rst_out_valid", a_out_valid, 1'b0);
    check_eq("rst_err_cnt", a_err_cnt, 8'd0);
    check_eq("rst_busy", a_busy, 1'b0);
    check_eq("rst_out_par", a_out_par, 1'b0);
    check_eq("rst_out_err", a_out_err, 1'b0);
    check_eq("rst_b_err_cnt", b_err_cnt, 2'd0);
    rst = 1'b0;
    tick();

    // Matching frame, latency from accept edge
    send(8'hA5, 1'b0);
    check_eq("busy_shift", a_busy, 1'b1);
    wait_out(lat);
    check_eq("latency", lat, DW + 1);
    check_eq("a5_par", a_out_par, 1'b0);
    check_eq("a5_err", a_out_err, 1'b0);
    take();
    check_eq("a5_err_cnt", a_err_cnt, 8'd0);

    // Mismatch with stalled consumer
    send(8'h07, 1'b0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_vld", a_out_valid, 1'b1);
      check_eq("stall_par", a_out_par, 1'b1);
      check_eq("stall_err", a_out_err, 1'b1);
      check_eq("stall_in_ready", a_in_ready, 1'b0);
      tick();
    end
    take();
    check_eq("07_err_cnt", a_err_cnt, 8'd1);
    check_eq("07_err_cnt_model", a_err_cnt, cnt_a);

    // Flush mid-shift
    send(8'hFF, 1'b0);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    void'(q_a.pop_back());
    void'(q_b.pop_back());
    check_eq("flush_busy", a_busy, 1'b0);
    check_eq("flush_out_valid", a_out_valid, 1'b0);
    check_eq("flush_in_ready", a_in_ready, 1'b1);
    check_eq("flush_err_cnt", a_err_cnt, 8'd1);
    seen_vld = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (a_out_valid) seen_vld = 1'b1;
      tick();
    end
    check_eq("flush_no_out", seen_vld, 1'b0);
    send(8'h01, 1'b1);
    wait_out(lat);
    check_eq("01_err", a_out_err, 1'b0);
    take();
    check_eq("01_err_cnt", a_err_cnt, 8'd1);

    // Flush beats an accept in IDLE
    in_valid = 1'b1; in_data = 8'h55; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0; in_data = '0;
    check_eq("flush_acc_busy", a_busy, 1'b0);
    check_eq("flush_acc_in_ready", a_in_ready, 1'b1);
    tick();
    check_eq("flush_acc_busy2", a_busy, 1'b0);

    // Reset mid-frame clears everything including counters
    send(8'h5A, 1'b1);
    tick(); tick();
    rst = 1'b1;
    tick();
    q_a.delete(); q_b.delete(); cnt_a = 0; cnt_b = 0;
    check_eq("rst_mid_busy", a_busy, 1'b0);
    check_eq("rst_mid_err_cnt", a_err_cnt, 8'd0);
    check_eq("rst_mid_b_err_cnt", b_err_cnt, 2'd0);
    rst = 1'b0;
    tick();
    check_eq("rst_mid_out_valid", a_out_valid, 1'b0);

    // Saturating counter on the 2-bit instance
    for (int i = 0; i < 4; i++) begin
      send(8'h03, 1'b0);
      wait_out(lat);
      take();
      check_eq("sat_b_err_cnt", b_err_cnt, sat_exp[i]);
    end
    check_eq("sat_a_err_cnt", a_err_cnt, 8'd0);

    // Odd parity of all-zeros word
    send(8'h00, 1'b0);
    wait_out(lat);
    check_eq("odd_zero_par", b_out_par, 1'b1);
    check_eq("even_zero_par", a_out_par, 1'b0);
    take();
    check_eq("odd_zero_sat", b_err_cnt, 2'd3);

    // Random frames with random consumer stall
    for (int i = 0; i < 8; i++) begin
      rd = DW'($urandom_range(0, 255));
      send(rd, 1'($urandom_range(0, 1)));
      wait_out(lat);
      repeat ($urandom_range(0, 3)) tick();
      take();
      check_eq("rnd_a_err_cnt", a_err_cnt, cnt_a);
      check_eq("rnd_b_err_cnt", b_err_cnt, cnt_b);
    end
    check_eq("q_a_drained", q_a.size(), 0);
    check_eq("q_b_drained", q_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
